lsu_rmw: RTL and testbench

Load/store unit between the CPU pipeline's memory stage and the word-only data memory. It accepts byte, half and word requests over a valid/ready handshake and turns them into whole-word accesses on the memory's read and write ports. Sub-word stores use a read-modify-write sequence. Load data is returned lane-extracted and sign- or zero-extended, with one response per request.

---
 rtl/lsu_rmw.sv | 138 +++++++++++++
 tb/tb_lsu_rmw.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_rmw.sv
// lsu_rmw: byte/half/word load-store unit over a word-only memory.
// Sub-word stores do a read-modify-write; loads are lane-extracted and extended.
module lsu_rmw #(
  parameter int NUMWORDS  = 4096,
  parameter int DATAWIDTH = 32,
  localparam int AW = $clog2(NUMWORDS) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [1:0]           req_size_i,
  input  logic                 req_unsigned_i,
  input  logic [31:0]          req_addr_i,
  input  logic [DATAWIDTH-1:0] req_wdata_i,
  output logic                 resp_valid_o,
  output logic [DATAWIDTH-1:0] resp_rdata_o,
  output logic                 resp_err_o,
  output logic                 mem_re_o,
  output logic [AW-1:0]        mem_raddr_o,
  input  logic [DATAWIDTH-1:0] mem_rdata_i,
  output logic                 mem_we_o,
  output logic [AW-1:0]        mem_waddr_o,
  output logic [DATAWIDTH-1:0] mem_wdata_o
);
  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;
  localparam logic [31:0] NW = 32'(NUMWORDS);
  state_t state_q, state_d;
  logic we_q, we_d, uns_q, uns_d;
  logic [1:0] size_q, size_d, off_q, off_d;
  logic [AW-1:0] idx_q, idx_d, mem_raddr_q, mem_raddr_d, mem_waddr_q, mem_waddr_d;
  logic [DATAWIDTH-1:0] wdata_q, wdata_d, resp_rdata_q, resp_rdata_d, mem_wdata_q, mem_wdata_d;
  logic resp_valid_q, resp_valid_d, resp_err_q, resp_err_d, mem_re_q, mem_re_d, mem_we_q, mem_we_d;
  logic req_err;
  logic [DATAWIDTH-1:0] sh, ld, mask, merged;
  assign req_err = (req_size_i == 2'b11) || (req_size_i == 2'b01 && req_addr_i[0])
                || (req_size_i == 2'b10 && |req_addr_i[1:0]) || ({2'b00, req_addr_i[31:2]} >= NW);
  // Lane shift by byte offset; halves are always 2-aligned so the same shift serves them.
  assign sh     = mem_rdata_i >> {off_q, 3'b000};
  assign ld     = size_q == 2'b00 ? {{24{~uns_q & sh[7]}}, sh[7:0]}
                : size_q == 2'b01 ? {{16{~uns_q & sh[15]}}, sh[15:0]} : mem_rdata_i;
  assign mask   = (size_q == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << {off_q, 3'b000};
  assign merged = (mem_rdata_i & ~mask)
                | ((size_q == 2'b00 ? {4{wdata_q[7:0]}} : {2{wdata_q[15:0]}}) & mask);
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    uns_d        = uns_q;
    size_d       = size_q;
    off_d        = off_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    mem_re_d     = 1'b0;
    mem_raddr_d  = '0;
    mem_we_d     = 1'b0;
    mem_waddr_d  = '0;
    mem_wdata_d  = '0;
    unique case (state_q)
      IDLE: if (req_valid_i) begin
        we_d    = req_we_i;
        uns_d   = req_unsigned_i;
        size_d  = req_size_i;
        off_d   = req_addr_i[1:0];
        idx_d   = req_addr_i[AW+1:2];
        wdata_d = req_wdata_i;
        state_d = req_err ? RESP : ACCESS;
        resp_valid_d = req_err;
        resp_err_d   = req_err;
        mem_we_d     = !req_err && req_we_i && req_size_i == 2'b10;
        mem_waddr_d  = mem_we_d ? req_addr_i[AW+1:2] : '0;
        mem_wdata_d  = mem_we_d ? req_wdata_i : '0;
        mem_re_d     = !req_err && !mem_we_d;
        mem_raddr_d  = mem_re_d ? req_addr_i[AW+1:2] : '0;
      end
      ACCESS: begin
        state_d      = (we_q && size_q != 2'b10) ? WRITE : RESP;
        resp_valid_d = state_d == RESP;
        resp_rdata_d = we_q ? '0 : ld;
        mem_we_d     = state_d == WRITE;
        mem_waddr_d  = mem_we_d ? idx_q : '0;
        mem_wdata_d  = mem_we_d ? merged : '0;
      end
      WRITE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      RESP: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= '0;
      off_q        <= '0;
      idx_q        <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_raddr_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_waddr_q  <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      uns_q        <= uns_d;
      size_q       <= size_d;
      off_q        <= off_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_re_q     <= mem_re_d;
      mem_raddr_q  <= mem_raddr_d;
      mem_we_q     <= mem_we_d;
      mem_waddr_q  <= mem_waddr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end
  assign req_ready_o  = state_q == IDLE;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;
  assign mem_re_o     = mem_re_q;
  assign mem_raddr_o  = mem_raddr_q;
  assign mem_we_o     = mem_we_q;
  assign mem_waddr_o  = mem_waddr_q;
  assign mem_wdata_o  = mem_wdata_q;
endmodule

// File: tb/tb_lsu_rmw.sv
// tb_lsu_rmw: randomized scoreboard bench for lsu_rmw against a byte-array memory model.
module tb_lsu_rmw;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic req_valid_i = 1'b0, req_ready_o, req_we_i = 1'b0, req_unsigned_i = 1'b0;
  logic [1:0] req_size_i = '0;
  logic [31:0] req_addr_i = '0, req_wdata_i = '0, resp_rdata_o, mem_rdata_i, mem_wdata_o;
  logic resp_valid_o, resp_err_o, mem_re_o, mem_we_o;
  logic [12:0] mem_raddr_o, mem_waddr_o;
  logic [31:0] mem [0:4095];
  logic [7:0] rb [0:16383];
  int checks = 0, errors = 0, cyc = 0;
  logic skip = 1'b0;
  typedef struct {
    logic err;
    logic [31:0] rdata;
    int a;
    int lat;
    logic rd1, wr1, wr2;
    logic [12:0] idx;
    logic [31:0] wword;
  } exp_t;
  exp_t q[$];

  lsu_rmw dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .resp_valid_o(resp_valid_o),
    .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o), .mem_re_o(mem_re_o),
    .mem_raddr_o(mem_raddr_o), .mem_rdata_i(mem_rdata_i), .mem_we_o(mem_we_o),
    .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  assign mem_rdata_i = mem[mem_raddr_o[11:0]];
  always @(posedge clk_i) if (mem_we_o) mem[mem_waddr_o[11:0]] <= mem_wdata_o;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {rb[4*w+3], rb[4*w+2], rb[4*w+1], rb[4*w]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns, input logic [31:0] addr);
    logic [31:0] v = '0;
    int nb = 1 << sz;
    int b = int'(addr[13:0]);
    for (int k = 0; k < nb; k++) v[8*k +: 8] = rb[b+k];
    if (!uns) for (int i = 8*nb; i < 32; i++) v[i] = v[8*nb-1];
    return v;
  endfunction

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input logic nopush = 1'b0);
    exp_t e;
    int n = 0;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = sz; req_unsigned_i = uns;
    req_addr_i = addr; req_wdata_i = wd;
    while (!req_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    if (!req_ready_o) begin
      errors++;
      $display("FAIL accept_timeout: ready stuck low, expected 1");
      return;
    end
    e.a = cyc;
    e.err = sz == 2'b11 || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 0) || addr >= 32'h4000;
    e.lat = e.err ? 1 : (we && sz != 2'b10) ? 3 : 2;
    e.rd1 = !e.err && !(we && sz == 2'b10);
    e.wr1 = !e.err && we && sz == 2'b10;
    e.wr2 = !e.err && we && sz != 2'b10;
    e.idx = e.err ? '0 : addr[14:2];
    e.rdata = '0;
    e.wword = '0;
    if (!e.err && !nopush) begin
      if (we) begin
        for (int k = 0; k < (1 << sz); k++) rb[int'(addr[13:0]) + k] = wd[8*k +: 8];
        e.wword = ref_word(int'(addr[13:2]));
      end else e.rdata = ref_load(sz, uns, addr);
    end
    @(posedge clk_i);
    if (!nopush) q.push_back(e);
  endtask

  task automatic idle(input int n);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    repeat (n) @(negedge clk_i);
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    logic ere, ewe;
    int k;
    if (!rst_i) begin
      if (!skip) begin
        ere = 1'b0;
        ewe = 1'b0;
        e.idx = '0;
        e.wword = '0;
        if (q.size() > 0) begin
          e = q[0];
          k = cyc - e.a;
          ere = e.rd1 && k == 1;
          ewe = (e.wr1 && k == 1) || (e.wr2 && k == 2);
        end
        chk("ready", 32'(req_ready_o), 32'(q.size() == 0));
        chk("mem_re", 32'(mem_re_o), 32'(ere));
        chk("mem_we", 32'(mem_we_o), 32'(ewe));
        chk("mem_raddr", 32'(mem_raddr_o), ere ? 32'(e.idx) : 32'd0);
        chk("mem_waddr", 32'(mem_waddr_o), ewe ? 32'(e.idx) : 32'd0);
        chk("mem_wdata", mem_wdata_o, ewe ? e.wword : 32'd0);
      end
      chk("re_we_exclusive", 32'(mem_re_o && mem_we_o), 32'd0);
      if (resp_valid_o) begin
        if (skip || q.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected: resp_valid_o=1 expected 0");
        end else begin
          e = q.pop_front();
          chk("resp_cycle", 32'(cyc), 32'(e.a + e.lat));
          chk("resp_err", 32'(resp_err_o), 32'(e.err));
          chk("resp_rdata", resp_rdata_o, e.rdata);
        end
      end else if (q.size() > 0 && cyc > q[0].a + q[0].lat) begin
        e = q.pop_front();
        errors++;
        $display("FAIL resp_timeout: no resp_valid_o by cycle %0d", e.a + e.lat);
      end
    end
  end

  initial begin
    logic [31:0] w;
    int n;
    logic [1:0] sz;
    logic [31:0] ad;
    for (int i = 0; i < 4096; i++) begin
      w = $urandom;
      mem[i] = w;
      for (int b = 0; b < 4; b++) rb[4*i+b] = w[8*b +: 8];
    end
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("reset_ready", 32'(req_ready_o), 32'd1);
    chk("reset_outs", {27'd0, resp_valid_o, resp_err_o, mem_re_o, mem_we_o, 1'b0}, 32'd0);
    chk("reset_data", resp_rdata_o | mem_wdata_o | 32'(mem_raddr_o) | 32'(mem_waddr_o), 32'd0);
    issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
    issue(0, 2'b10, 0, 32'h10, 32'h0);
    issue(1, 2'b10, 0, 32'h10, 32'h11223344);
    issue(1, 2'b00, 0, 32'h11, 32'h5555_55AA);
    issue(0, 2'b10, 0, 32'h10, 32'h0);
    issue(1, 2'b10, 0, 32'h10, 32'h8000FF7F);
    issue(0, 2'b00, 0, 32'h11, 32'h0);
    issue(0, 2'b01, 1, 32'h12, 32'h0);
    issue(0, 2'b01, 0, 32'h12, 32'h0);
    issue(0, 2'b00, 0, 32'h10, 32'h0);
    issue(0, 2'b10, 0, 32'h12, 32'h0);
    issue(0, 2'b01, 0, 32'h13, 32'h0);
    issue(0, 2'b11, 0, 32'h0, 32'h0);
    issue(0, 2'b10, 0, 32'h4000, 32'h0);
    issue(0, 2'b10, 1, 32'h3FFC, 32'h0);
    idle(3);
    chk("mem4_final_directed", mem[4], 32'h8000FF7F);
    skip = 1'b1;
    issue(1, 2'b01, 0, 32'h22, 32'hCAFE_BEEF, 1'b1);
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_write_pending", 32'(mem_we_o), 32'd1);
    rst_i = 1'b1;
    req_valid_i = 1'b0;
    #1;
    chk("rst_abort_outs", {27'd0, resp_valid_o, resp_err_o, mem_re_o, mem_we_o, 1'b0}, 32'd0);
    chk("rst_abort_data", resp_rdata_o | mem_wdata_o | 32'(mem_raddr_o) | 32'(mem_waddr_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    chk("rst_no_write", mem[8], ref_word(8));
    @(negedge clk_i);
    skip = 1'b0;
    for (int i = 0; i < 300; i++) begin
      n = $urandom_range(0, 15);
      sz = n < 5 ? 2'b00 : n < 10 ? 2'b01 : n < 14 ? 2'b10 : 2'b11;
      n = $urandom_range(0, 19);
      ad = n == 0 ? $urandom : n == 1 ? 32'h3FFC + $urandom_range(0, 7) : 32'($urandom_range(0, 255));
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 3));
    end
    idle(1);
    n = 0;
    while (q.size() > 0 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", q.size());
    end
    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_word(i));
    chk("final_mem_last", mem[4095], ref_word(4095));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
